// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor stage plus a borrow flop,
// computing a - b - bin over WIDTH clocks behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             x, y, d_bit, br_nxt;
    logic [WIDTH-1:0] sr_w;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        x      = sa_q[0];
        y      = sb_q[0];
        d_bit  = x ^ y ^ br_q;
        br_nxt = (~x & y) | (~(x ^ y) & br_q);
        // The top result bit lives in the stage output, not in sr.
        sr_w   = {d_bit, sr_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_d  = sr_w[WIDTH-1:1];
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = sr_w;
                    bout_d  = br_nxt;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 vectors
// and an exhaustive back-to-back WIDTH=4 sweep.
module tb_serial_subtractor;

    typedef struct {
        logic [8:0] res;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic       s8 = 1'b0, bi8 = 1'b0, r8, bz8, d8, bo8;
    logic [7:0] a8 = '0, b8 = '0, df8;
    logic       s4 = 1'b0, bi4 = 1'b0, r4, bz4, d4, bo4;
    logic [3:0] a4 = '0, b4 = '0, df4;

    exp_t q8[$];
    exp_t q4[$];

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bi8),
        .ready(r8), .busy(bz8), .done(d8), .diff(df8), .bout(bo8)
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bi4),
        .ready(r4), .busy(bz4), .done(d4), .diff(df4), .bout(bo4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (d8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_result", {23'd0, bo8, df8}, {23'd0, e.res});
                chk("w8_latency", cyc - e.acc, 8);
            end
        end
    end

    always @(negedge clk) begin
        if (d4) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("w4_result", {27'd0, bo4, df4}, {27'd0, e.res[4:0]});
                chk("w4_latency", cyc - e.acc, 4);
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input logic [8:0] exp);
        int n = 0;
        exp_t e;
        @(negedge clk);
        s8 = 1'b0;
        while (!r8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!r8) chk("w8_ready_timeout", 0, 1);
        s8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
        @(posedge clk);
        #1;
        e.res = exp;
        e.acc = cyc;
        q8.push_back(e);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic bi);
        int n = 0;
        exp_t e;
        @(negedge clk);
        s4 = 1'b0;
        while (!r4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!r4) chk("w4_ready_timeout", 0, 1);
        s4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
        @(posedge clk);
        #1;
        e.res = {4'd0, 5'({1'b0, a} - {1'b0, b} - {4'd0, bi})};
        e.acc = cyc;
        q4.push_back(e);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_ready", r8, 1);
        chk("rst_busy", bz8, 0);
        chk("rst_done", d8, 0);
        chk("rst_result", {bo8, df8}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: handshake timing of a single operation
        op8(8'h05, 8'h03, 1'b0, 9'h002);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) s8 = 1'b0;
            chk("t1_busy", {bz8, r8, d8}, 3'b100);
        end
        @(negedge clk);
        chk("t1_done_cycle", {bz8, r8, d8}, 3'b001);
        @(negedge clk);
        chk("t1_ready_after", {bz8, r8, d8}, 3'b010);

        op8(8'h03, 8'h05, 1'b0, 9'h1FE);
        op8(8'hFF, 8'hFF, 1'b0, 9'h000);
        op8(8'h00, 8'h00, 1'b1, 9'h1FF);

        // Stray starts during RUN and DONE must be ignored
        op8(8'h80, 8'h01, 1'b0, 9'h07F);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2 || k == 5 || k == 9) begin
                s8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
            end else begin
                s8 = 1'b0;
            end
            if (k <= 8) chk("t3_diff_hold", {bo8, df8}, 9'h1FF);
        end
        @(negedge clk);
        s8 = 1'b0;
        chk("t3_idle_after", {bz8, r8}, 2'b01);
        @(negedge clk);
        chk("t3_no_restart", {bz8, r8}, 2'b01);

        // Asynchronous reset mid-operation aborts it
        op8(8'h55, 8'h11, 1'b0, 9'h044);
        repeat (4) begin
            @(negedge clk);
            s8 = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        q8.delete();
        chk("t4_rst_flags", {bz8, r8, d8}, 3'b010);
        chk("t4_rst_result", {bo8, df8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(8'h10, 8'h01, 1'b0, 9'h00F);
        @(negedge clk);
        s8 = 1'b0;

        // Exhaustive WIDTH=4 at maximum accept rate
        for (int ai = 0; ai < 16; ai++)
            for (int bj = 0; bj < 16; bj++)
                for (int c = 0; c < 2; c++)
                    op4(4'(ai), 4'(bj), 1'(c));
        @(negedge clk);
        s4 = 1'b0;

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_w8", q8.size(), 0);
        chk("drain_w4", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
